// File: rtl/dpram_fifo_ctrl_pkg.sv
// Shared constants for the dual-ported RAM FIFO controller and its arbiter.
package dpram_fifo_ctrl_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 11;
  localparam int FIFO_LEVEL_W          = DEFAULT_ADDRESS_WIDTH + 1;

  localparam int REQ_RX   = 0;
  localparam int REQ_HOST = 1;

  // Occupancy needs one bit more than the address so that DEPTH itself fits.
  function automatic int level_width(input int address_width);
    return address_width + 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the requester not granted last time wins a tie.
module rr_arb2
  import dpram_fifo_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant[REQ_RX]   = 1'b1;
      2'b10:   grant[REQ_HOST] = 1'b1;
      2'b11: begin
        if (last_grant) grant[REQ_RX] = 1'b1;
        else            grant[REQ_HOST] = 1'b1;
      end
      default: grant = 2'b00;
    endcase
  end

  // Reset value of 1 lets the RX requester win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_grant <= 1'b1;
    else if (advance) last_grant <= grant[REQ_HOST];
  end

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Circular FIFO controller over an external dual-ported RAM, shared by two
// arbitrated write requesters and drained by one valid/ready consumer.
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int AFULL_LEVEL   = (1 << ADDRESS_WIDTH) - 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr0_valid,
  input  logic [DATA_WIDTH-1:0]    wr0_data,
  output logic                     wr0_ready,
  input  logic                     wr1_valid,
  input  logic [DATA_WIDTH-1:0]    wr1_data,
  output logic                     wr1_ready,
  output logic                     rd_valid,
  output logic [DATA_WIDTH-1:0]    rd_data,
  input  logic                     rd_ready,
  input  logic                     flush,
  output logic [ADDRESS_WIDTH:0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [ADDRESS_WIDTH-1:0] ram_write_address,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_address,
  input  logic [DATA_WIDTH-1:0]    ram_read_data
);

  localparam int LEVEL_W = level_width(ADDRESS_WIDTH);
  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(1) << ADDRESS_WIDTH;
  localparam logic [LEVEL_W-1:0] AFULL_L = LEVEL_W'(AFULL_LEVEL);

  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH-1:0] rd_ptr;
  logic [LEVEL_W-1:0]       count;
  logic [1:0]               grant;
  logic                     wr_accept;
  logic                     rd_accept;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({wr1_valid, wr0_valid}),
    .advance (wr_accept),
    .grant   (grant)
  );

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_L);
  assign almost_full = (count >= AFULL_L);
  assign level       = count;

  // Full is judged on the current count, so a read from a full FIFO frees a
  // slot for writers only from the following cycle.
  assign wr0_ready = grant[REQ_RX]   & ~full & ~flush & ~rst;
  assign wr1_ready = grant[REQ_HOST] & ~full & ~flush & ~rst;
  assign wr_accept = (wr0_valid & wr0_ready) | (wr1_valid & wr1_ready);

  assign ram_write_enable  = wr_accept;
  assign ram_write_address = wr_ptr;
  assign ram_write_data    = grant[REQ_HOST] ? wr1_data : wr0_data;

  assign rd_valid         = ~empty & ~flush;
  assign rd_accept        = rd_valid & rd_ready;
  assign ram_read_address = rd_ptr;
  assign rd_data          = ram_read_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Sequencing controller that runs a dual-ported byte RAM as a circular FIFO shared by two write requesters. Typical requesters are the RX bit-to-byte decoder and the host configuration path. A round-robin arbiter grants the single RAM write port, and a read pointer streams bytes to one consumer over valid/ready. The controller drives the RAM address, data and enable lines. The RAM stays external, with a synchronous write and a combinational (same-cycle) read.

## Interface
Parameters:
- DATA_WIDTH, 8, byte/word width of the RAM and all data ports
- ADDRESS_WIDTH, 11, RAM address width; DEPTH = 1<<ADDRESS_WIDTH
- AFULL_LEVEL, DEPTH-16, level at or above which almost_full asserts

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr0_valid / wr0_data / wr0_ready  in / in / out  1 / DATA_WIDTH / 1  requester 0 write channel
- wr1_valid / wr1_data / wr1_ready  in / in / out  1 / DATA_WIDTH / 1  requester 1 write channel
- rd_valid / rd_data / rd_ready  out / out / in  1 / DATA_WIDTH / 1  consumer read channel
- flush  in  1  synchronous clear of FIFO contents
- level  out  ADDRESS_WIDTH+1  current occupancy, 0..DEPTH
- empty / full / almost_full  out  1 each  status flags
- ram_write_address / ram_write_data / ram_write_enable  out  ADDRESS_WIDTH / DATA_WIDTH / 1  RAM write port
- ram_read_address  out  ADDRESS_WIDTH  RAM read address
- ram_read_data  in  DATA_WIDTH  RAM read data, combinational from ram_read_address

## Operation
**Registered state**
- wr_ptr and rd_ptr, both ADDRESS_WIDTH wide; they wrap naturally modulo DEPTH.
- count, ADDRESS_WIDTH+1 wide.
- last_grant, 1 bit.

**Write arbitration**
- The grant is combinational.
- If only one requester is valid, that requester is granted.
- If both are valid, the requester other than last_grant is granted.
- wrN_ready = grantN & ~full & ~flush & ~rst.
- An accepted write is valid & ready on the granted channel.
- On an accepted write:
  - ram_write_enable = 1, ram_write_address = wr_ptr, ram_write_data = the granted data.
  - wr_ptr increments and last_grant is set to the granted index.
- ram_write_enable is combinational and is never asserted without an acceptance.

**Read side**
- ram_read_address = rd_ptr.
- rd_data = ram_read_data.
- rd_valid = ~empty & ~flush.
- On rd_valid & rd_ready, rd_ptr increments.

**Count update**
- count += accepted write, −= accepted read.
- A simultaneous write and read leaves count unchanged.

**Flags**
- empty = (count == 0).
- full = (count == DEPTH).
- almost_full = (count >= AFULL_LEVEL).
- level = count.

**Flush**
- Flush has priority over everything.
- In a flush cycle, no write or read is accepted.
- Next cycle: wr_ptr = rd_ptr = count = 0. last_grant is kept.

**Reset**
- Asynchronous reset sets wr_ptr, rd_ptr and count to 0 and last_grant to 1, so wr0 wins the first tie.
- Outputs during reset:
  - rd_valid = 0, wr0_ready = wr1_ready = 0, ram_write_enable = 0.
  - empty = 1, full = 0, almost_full = 0, level = 0.
- A reset that lands mid-stream discards all contents. RAM contents are not cleared.

## Timing
- Write-to-read latency is 1 cycle. A byte accepted at edge N is visible on rd_valid/rd_data after edge N, with count ≥ 1.
- Back-to-back throughput is 1 write and 1 read per cycle.
- When empty, read and write can never target the same address in one cycle, because rd_valid = 0.
- When full with rd_ready = 1:
  - The read is accepted, but wrN_ready stays 0 in that cycle because full is evaluated on the current count.
  - A write can be accepted from the next cycle.
- When empty, a write is accepted while rd_valid = 0.
- wrN_ready may depend on the other requester's valid. Requesters must not make valid depend on ready.
- Pointer wrap from DEPTH−1 to 0 needs no special handling.

## Structure
- Shared package contents:
  - FIFO_LEVEL_W = ADDRESS_WIDTH+1.
  - Requester index constants REQ_RX = 0 and REQ_HOST = 1.
- One sub-module, rr_arb2: a two-input round-robin arbiter.
  - Inputs: clk, rst, req[1:0], advance.
  - Outputs: one-hot grant[1:0].
  - It owns last_grant.
- Pointer, count and flag logic stay in dpram_fifo_ctrl.

## Test plan
All scenarios use ADDRESS_WIDTH = 3 (DEPTH = 8) and AFULL_LEVEL = 6.
- **Reset/idle:** assert rst mid-cycle → all outputs at their reset values immediately; after release, a wr0 write of 0xA5 → rd_valid next cycle with rd_data = 0xA5, level = 1.
- **Arbitration:** both requesters valid every cycle, data 0x10.. and 0x20.. → grants alternate wr0, wr1, wr0 …; read order is 0x10, 0x20, 0x11, 0x21.
- **Full/wrap:**
  - Fill 8 bytes (0x00–0x07) with rd_ready = 0 → full = 1, almost_full = 1, both ready = 0.
  - One read → full drops.
  - Write 0x08 → data lands at address 0.
  - Drain → order 0x01..0x08.
- **Simultaneous read/write at level 3:** sustained stream for 20 cycles → level stays 3, output sequence is in order with no loss.
- **Flush:** with level 5, assert flush with wr0_valid = 1 and rd_ready = 1 → nothing accepted in that cycle; next cycle level = 0, empty = 1, ram_write_enable stayed 0.
- **Reset mid-stream:** with level 4, pulse rst → level = 0 and rd_valid = 0; the next write 0x5A is read back first.
